// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between MEM/WB and a long-latency unit.
// Optional WB_ARB_BYPASS_EN lets an lu result skip the FIFO on idle cycles.
module wb_port_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wb_RegWrite_i,
   input  logic [4:0]               wb_rd_addr_i,
   input  logic [31:0]              wb_data_i,
   input  logic                     lu_valid_i,
   input  logic [4:0]               lu_rd_addr_i,
   input  logic [31:0]              lu_data_i,
   output logic                     lu_ready_o,
   output logic                     stall_o,
   output logic                     RegWrite_o,
   output logic [4:0]               rd_addr_o,
   output logic [31:0]              rd_data_o,
   output logic [$clog2(DEPTH):0]   pending_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [GW-1:0] AGE_MAX  = GW'(STARVE_MAX);

   logic [4:0]    rd_mem  [DEPTH];
   logic [31:0]   dat_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [GW-1:0] age;

   logic empty;
   logic full;
   logic accept;
   logic keep;
   logic live;
   logic pop;
   logic push;
   logic bypass;

   assign empty      = (count == '0);
   assign full       = (count == FULL_CNT);
   assign lu_ready_o = ~full & ~rst_i;
   assign stall_o    = (age == AGE_MAX);
   assign pending_o  = count;

   assign accept = lu_valid_i & lu_ready_o;
   assign keep   = accept & (|lu_rd_addr_i);
   assign live   = wb_RegWrite_i & (|wb_rd_addr_i) & ~stall_o;
   assign pop    = ~empty & (stall_o | ~live);

`ifdef WB_ARB_BYPASS_EN
   assign bypass = keep & empty & ~live & ~stall_o;
`else
   assign bypass = 1'b0;
`endif

   assign push = keep & ~bypass;

   always_ff @(posedge clk_i) begin
      if (push) begin
         rd_mem[wr_ptr]  <= lu_rd_addr_i;
         dat_mem[wr_ptr] <= lu_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         age        <= '0;
         RegWrite_o <= 1'b0;
         rd_addr_o  <= '0;
         rd_data_o  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);

         if (push & ~pop)
            count <= count + CW'(1);
         else if (pop & ~push)
            count <= count - CW'(1);

         // age tracks how long the current head has waited without a pop
         if (pop | empty)
            age <= '0;
         else if (!stall_o)
            age <= age + GW'(1);

         if (pop) begin
            RegWrite_o <= 1'b1;
            rd_addr_o  <= rd_mem[rd_ptr];
            rd_data_o  <= dat_mem[rd_ptr];
         end else if (live) begin
            RegWrite_o <= 1'b1;
            rd_addr_o  <= wb_rd_addr_i;
            rd_data_o  <= wb_data_i;
         end else if (bypass) begin
            RegWrite_o <= 1'b1;
            rd_addr_o  <= lu_rd_addr_i;
            rd_data_o  <= lu_data_i;
         end else begin
            RegWrite_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random checks of wb_port_arbiter against a queue-based model.
// Build with WB_ARB_BYPASS_EN defined to exercise the bypass variant.
module tb_wb_port_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_d;
   logic        lu_v;
   logic [4:0]  lu_rd;
   logic [31:0] lu_d;
   logic        lu_ready;
   logic        stall;
   logic        reg_we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  pending;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .wb_RegWrite_i(wb_we),
      .wb_rd_addr_i(wb_rd),
      .wb_data_i(wb_d),
      .lu_valid_i(lu_v),
      .lu_rd_addr_i(lu_rd),
      .lu_data_i(lu_d),
      .lu_ready_o(lu_ready),
      .stall_o(stall),
      .RegWrite_o(reg_we),
      .rd_addr_o(rd_addr),
      .rd_data_o(rd_data),
      .pending_o(pending)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference state: queued results as {rd, data}, head wait time, port
   logic [36:0] q[$];
   int          m_age;
   logic        e_we;
   logic [4:0]  e_rd;
   logic [31:0] e_d;
   logic        was_stall;
   logic        h_we;
   logic [4:0]  h_rd;
   logic [31:0] h_d;
   int          stall_seen;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_age     = 0;
      e_we      = 1'b0;
      e_rd      = '0;
      e_d       = '0;
      was_stall = 1'b0;
   endtask

   task automatic cycle(input logic we, input logic [4:0] rd,
                        input logic [31:0] d, input logic lv,
                        input logic [4:0] lrd, input logic [31:0] ld);
      logic        m_stall;
      logic        live;
      logic        keep;
      logic        popped;
      int          sz;
      logic [36:0] e;
      @(negedge clk);
      // MEM/WB held its instruction during the stall, so it reappears now
      if (was_stall) begin
         we = h_we;
         rd = h_rd;
         d  = h_d;
      end
      h_we  = we;
      h_rd  = rd;
      h_d   = d;
      wb_we = we;
      wb_rd = rd;
      wb_d  = d;
      lu_v  = lv;
      lu_rd = lrd;
      lu_d  = ld;
      #1;
      sz      = q.size();
      m_stall = (m_age == STARVE_MAX);
      check("lu_ready", 32'(lu_ready), 32'(sz < DEPTH));
      check("stall", 32'(stall), 32'(m_stall));
      check("pending", 32'(pending), 32'(sz));
      if (stall === 1'b1)
         stall_seen++;

      live   = we && (rd != 0) && !m_stall;
      keep   = lv && (sz < DEPTH) && (lrd != 0);
      popped = 1'b0;
      if (sz > 0 && (m_stall || !live)) begin
         e      = q.pop_front();
         e_we   = 1'b1;
         e_rd   = e[36:32];
         e_d    = e[31:0];
         popped = 1'b1;
      end else if (live) begin
         e_we = 1'b1;
         e_rd = rd;
         e_d  = d;
`ifdef WB_ARB_BYPASS_EN
      end else if (keep && sz == 0 && !m_stall) begin
         e_we = 1'b1;
         e_rd = lrd;
         e_d  = ld;
         keep = 1'b0;
`endif
      end else begin
         e_we = 1'b0;
      end
      if (popped || sz == 0)
         m_age = 0;
      else if (m_age < STARVE_MAX)
         m_age++;
      if (keep)
         q.push_back({lrd, ld});
      was_stall = m_stall;

      @(posedge clk);
      #1;
      check("RegWrite", 32'(reg_we), 32'(e_we));
      check("rd_addr", 32'(rd_addr), 32'(e_rd));
      check("rd_data", rd_data, e_d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      wb_we = 1'b0;
      wb_rd = '0;
      wb_d  = '0;
      lu_v  = 1'b0;
      lu_rd = '0;
      lu_d  = '0;
      h_we  = 1'b0;
      h_rd  = '0;
      h_d   = '0;
      stall_seen = 0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("rst_lu_ready", 32'(lu_ready), 32'd0);
      check("rst_RegWrite", 32'(reg_we), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      idle(1);
      cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
      check("pipe_rd5", 32'(rd_addr), 32'd5);
      check("pipe_data", rd_data, 32'h1234);

      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
      idle(2);
      check("lu_drained", 32'(pending), 32'd0);

      // pipeline busy every cycle while two results queue up
      stall_seen = 0;
      cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd20, 32'hC0);
      cycle(1'b1, 5'd2, 32'h102, 1'b1, 5'd21, 32'hC1);
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 5'(3 + i), 32'h200 + i, 1'b1, 5'd22, 32'hC2);
      check("one_stall", 32'(stall_seen), 32'd1);
      idle(4);

      cycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'h55);
      cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      check("r0_pops_lu", 32'(rd_addr), 32'd12);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
      idle(1);
      check("lu_r0_dropped", 32'(pending), 32'd0);

      cycle(1'b1, 5'd8, 32'h88, 1'b1, 5'd13, 32'hD3);
      cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd14, 32'hD4);
      @(negedge clk);
      check("full_pending", 32'(pending), 32'(q.size()));
      wb_we = 1'b0;
      lu_v  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async_pending", 32'(pending), 32'd0);
      check("async_RegWrite", 32'(reg_we), 32'd0);
      check("async_ready", 32'(lu_ready), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      idle(4);

      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
               $urandom(),
               1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
               $urandom());
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
